// File: rtl/ysyx_23060136_mem_stage.sv
// Memory-access stage: one data-memory transaction per load/store on a valid/ready
// channel, load alignment/extension, and a busy stall until the access completes.
module ysyx_23060136_mem_stage #(
    parameter int BITS_W = 32,
    parameter int INST_W = 32,
    parameter int GPR_W  = 5,
    parameter int CSR_W  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  FORWARD_stallWB,
    input  logic                  MEM_i_commit,
    input  logic [BITS_W-1:0]     MEM_i_pc,
    input  logic [INST_W-1:0]     MEM_i_inst,
    input  logic [BITS_W-1:0]     MEM_i_ALU_ALUout,
    input  logic [BITS_W-1:0]     MEM_i_ALU_CSR_out,
    input  logic [BITS_W-1:0]     MEM_i_rs2_data,
    input  logic                  MEM_i_write_gpr,
    input  logic                  MEM_i_write_csr_1,
    input  logic                  MEM_i_write_csr_2,
    input  logic                  MEM_i_mem_to_reg,
    input  logic [GPR_W-1:0]      MEM_i_rd,
    input  logic [CSR_W-1:0]      MEM_i_csr_rd_1,
    input  logic [CSR_W-1:0]      MEM_i_csr_rd_2,
    input  logic                  MEM_i_system_halt,
    input  logic                  MEM_i_mem_ren,
    input  logic                  MEM_i_mem_wen,
    input  logic [2:0]            MEM_i_funct3,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic [BITS_W-1:0]     dmem_req_addr,
    output logic                  dmem_req_wen,
    output logic [BITS_W-1:0]     dmem_req_wdata,
    output logic [BITS_W/8-1:0]   dmem_req_wstrb,
    input  logic                  dmem_resp_valid,
    input  logic [BITS_W-1:0]     dmem_resp_rdata,
    output logic [BITS_W-1:0]     MEM_o_rdata,
    output logic                  MEM_o_busy,
    output logic                  MEM_o_commit,
    output logic [BITS_W-1:0]     MEM_o_pc,
    output logic [INST_W-1:0]     MEM_o_inst,
    output logic [BITS_W-1:0]     MEM_o_ALU_ALUout,
    output logic [BITS_W-1:0]     MEM_o_ALU_CSR_out,
    output logic                  MEM_o_write_gpr,
    output logic                  MEM_o_write_csr_1,
    output logic                  MEM_o_write_csr_2,
    output logic                  MEM_o_mem_to_reg,
    output logic [GPR_W-1:0]      MEM_o_rd,
    output logic [CSR_W-1:0]      MEM_o_csr_rd_1,
    output logic [CSR_W-1:0]      MEM_o_csr_rd_2,
    output logic                  MEM_o_system_halt
);
    localparam int STRB_W = BITS_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    state_t state, state_nxt;

    logic              access, is_half, is_word, misalign, start;
    logic [1:0]        off;
    logic [BITS_W-1:0] st_wdata;
    logic [STRB_W-1:0] st_wstrb;

    logic [BITS_W-1:0] req_addr_q, req_wdata_q, rdata_q;
    logic [STRB_W-1:0] req_wstrb_q;
    logic              req_wen_q, req_ren_q;
    logic [2:0]        req_f3_q;
    logic [1:0]        req_off_q;
    logic [BITS_W-1:0] shifted, load_ext;

    assign access   = MEM_i_mem_ren | MEM_i_mem_wen;
    assign off      = MEM_i_ALU_ALUout[1:0];
    assign is_half  = (MEM_i_funct3[1:0] == 2'b01);
    assign is_word  = MEM_i_funct3[1];
    assign misalign = access & ((is_half & off[0]) | (is_word & (off != 2'b00)));
    assign start    = access & ~misalign;

    // Store lanes are replicated so the addressed byte lanes carry the data.
    always_comb begin
        st_wdata = MEM_i_rs2_data;
        st_wstrb = '1;
        if (!MEM_i_mem_wen) begin
            st_wdata = '0;
            st_wstrb = '0;
        end else if (is_half) begin
            st_wdata = {(BITS_W/16){MEM_i_rs2_data[15:0]}};
            st_wstrb = STRB_W'(2'b11) << off;
        end else if (!is_word) begin
            st_wdata = {(BITS_W/8){MEM_i_rs2_data[7:0]}};
            st_wstrb = STRB_W'(1'b1) << off;
        end
    end

    always_comb begin
        shifted = dmem_resp_rdata >> {req_off_q, 3'b000};
        case (req_f3_q[1:0])
            2'b00:   load_ext = {{(BITS_W-8){~req_f3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{(BITS_W-16){~req_f3_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_ext = dmem_resp_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        dmem_req_valid = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_REQ;
            S_REQ: begin
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: if (dmem_resp_valid) state_nxt = S_DONE;
            S_DONE: if (!FORWARD_stallWB) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            req_wen_q   <= 1'b0;
            req_ren_q   <= 1'b0;
            req_f3_q    <= '0;
            req_off_q   <= '0;
            rdata_q     <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                req_addr_q  <= {MEM_i_ALU_ALUout[BITS_W-1:2], 2'b00};
                req_wdata_q <= st_wdata;
                req_wstrb_q <= st_wstrb;
                req_wen_q   <= MEM_i_mem_wen;
                req_ren_q   <= MEM_i_mem_ren;
                req_f3_q    <= MEM_i_funct3;
                req_off_q   <= off;
            end
            if (state == S_WAIT && dmem_resp_valid && req_ren_q)
                rdata_q <= load_ext;
        end
    end

    assign dmem_req_addr  = req_addr_q;
    assign dmem_req_wen   = req_wen_q;
    assign dmem_req_wdata = req_wdata_q;
    assign dmem_req_wstrb = req_wstrb_q;

    assign MEM_o_busy  = rst & start & (state != S_DONE);
    assign MEM_o_rdata = (state == S_DONE && req_ren_q && !misalign) ? rdata_q : '0;

    assign MEM_o_commit      = MEM_i_commit;
    assign MEM_o_pc          = MEM_i_pc;
    assign MEM_o_inst        = MEM_i_inst;
    assign MEM_o_ALU_ALUout  = MEM_i_ALU_ALUout;
    assign MEM_o_ALU_CSR_out = MEM_i_ALU_CSR_out;
    assign MEM_o_write_gpr   = MEM_i_write_gpr;
    assign MEM_o_write_csr_1 = MEM_i_write_csr_1;
    assign MEM_o_write_csr_2 = MEM_i_write_csr_2;
    assign MEM_o_mem_to_reg  = MEM_i_mem_to_reg;
    assign MEM_o_rd          = MEM_i_rd;
    assign MEM_o_csr_rd_1    = MEM_i_csr_rd_1;
    assign MEM_o_csr_rd_2    = MEM_i_csr_rd_2;
    assign MEM_o_system_halt = MEM_i_system_halt | misalign;
endmodule

// File: tb/tb_ysyx_23060136_mem_stage.sv
// Scoreboard bench for ysyx_23060136_mem_stage: random loads/stores against a
// word-array memory model, with a responder that varies ready/response latency.
module tb_ysyx_23060136_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        FORWARD_stallWB, MEM_i_commit;
    logic [31:0] MEM_i_pc, MEM_i_inst, MEM_i_ALU_ALUout, MEM_i_ALU_CSR_out, MEM_i_rs2_data;
    logic        MEM_i_write_gpr, MEM_i_write_csr_1, MEM_i_write_csr_2, MEM_i_mem_to_reg;
    logic [4:0]  MEM_i_rd;
    logic [11:0] MEM_i_csr_rd_1, MEM_i_csr_rd_2;
    logic        MEM_i_system_halt, MEM_i_mem_ren, MEM_i_mem_wen;
    logic [2:0]  MEM_i_funct3;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_wen, dmem_resp_valid;
    logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_resp_rdata, MEM_o_rdata;
    logic [3:0]  dmem_req_wstrb;
    logic        MEM_o_busy, MEM_o_commit, MEM_o_write_gpr, MEM_o_write_csr_1, MEM_o_write_csr_2;
    logic        MEM_o_mem_to_reg, MEM_o_system_halt;
    logic [31:0] MEM_o_pc, MEM_o_inst, MEM_o_ALU_ALUout, MEM_o_ALU_CSR_out;
    logic [4:0]  MEM_o_rd;
    logic [11:0] MEM_o_csr_rd_1, MEM_o_csr_rd_2;

    always #5 clk = ~clk;

    ysyx_23060136_mem_stage #(.BITS_W(32), .INST_W(32), .GPR_W(5), .CSR_W(12)) dut (
        .clk(clk), .rst(rst_n), .FORWARD_stallWB(FORWARD_stallWB),
        .MEM_i_commit(MEM_i_commit), .MEM_i_pc(MEM_i_pc), .MEM_i_inst(MEM_i_inst),
        .MEM_i_ALU_ALUout(MEM_i_ALU_ALUout), .MEM_i_ALU_CSR_out(MEM_i_ALU_CSR_out),
        .MEM_i_rs2_data(MEM_i_rs2_data), .MEM_i_write_gpr(MEM_i_write_gpr),
        .MEM_i_write_csr_1(MEM_i_write_csr_1), .MEM_i_write_csr_2(MEM_i_write_csr_2),
        .MEM_i_mem_to_reg(MEM_i_mem_to_reg), .MEM_i_rd(MEM_i_rd),
        .MEM_i_csr_rd_1(MEM_i_csr_rd_1), .MEM_i_csr_rd_2(MEM_i_csr_rd_2),
        .MEM_i_system_halt(MEM_i_system_halt), .MEM_i_mem_ren(MEM_i_mem_ren),
        .MEM_i_mem_wen(MEM_i_mem_wen), .MEM_i_funct3(MEM_i_funct3),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_wen(dmem_req_wen),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .MEM_o_rdata(MEM_o_rdata), .MEM_o_busy(MEM_o_busy), .MEM_o_commit(MEM_o_commit),
        .MEM_o_pc(MEM_o_pc), .MEM_o_inst(MEM_o_inst), .MEM_o_ALU_ALUout(MEM_o_ALU_ALUout),
        .MEM_o_ALU_CSR_out(MEM_o_ALU_CSR_out), .MEM_o_write_gpr(MEM_o_write_gpr),
        .MEM_o_write_csr_1(MEM_o_write_csr_1), .MEM_o_write_csr_2(MEM_o_write_csr_2),
        .MEM_o_mem_to_reg(MEM_o_mem_to_reg), .MEM_o_rd(MEM_o_rd),
        .MEM_o_csr_rd_1(MEM_o_csr_rd_1), .MEM_o_csr_rd_2(MEM_o_csr_rd_2),
        .MEM_o_system_halt(MEM_o_system_halt)
    );

    typedef struct {logic [31:0] addr; logic [31:0] wdata; logic wen; logic [3:0] wstrb;} req_t;
    typedef struct {logic [31:0] rdata; logic halt; int hs; logic [31:0] pc; logic [31:0] alu; logic [4:0] rd;} out_t;

    req_t        exp_req[$];
    out_t        exp_out[$];
    logic [31:0] mem_model [16];
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int          checks = 0, errors = 0;
    int          rdy_dly = 0, rsp_dly = 0;
    logic        resp_en = 1'b1, in_flight = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b", nm, act, exp);
        end
    endtask

    // Memory responder: ready after rdy_dly cycles, response rsp_dly cycles after handshake.
    initial begin
        logic [31:0] a;
        logic        w;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
        forever begin
            @(posedge clk) #1;
            if (rst_n && resp_en && dmem_req_valid) begin
                for (int i = 0; i < rdy_dly; i++) @(posedge clk) #1;
                dmem_req_ready = 1'b1;
                a = dmem_req_addr;
                w = dmem_req_wen;
                @(posedge clk) #1;
                dmem_req_ready = 1'b0;
                for (int i = 0; i < rsp_dly; i++) @(posedge clk) #1;
                dmem_resp_valid = 1'b1;
                dmem_resp_rdata = w ? $urandom : mem_model[a[5:2]];
                @(posedge clk) #1;
                dmem_resp_valid = 1'b0;
                dmem_resp_rdata = $urandom;
            end
        end
    end

    // Monitor: checks requests on the bus and each instruction's outputs as it leaves.
    initial begin
        int hs_cnt;
        hs_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) hs_cnt = 0;
            else begin
                if (dmem_req_valid) begin
                    if (exp_req.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req act=valid exp=no_request");
                    end else begin
                        chk("req_addr", dmem_req_addr, exp_req[0].addr);
                        chk("req_wdata", dmem_req_wdata, exp_req[0].wdata);
                        chk("req_wstrb", {28'b0, dmem_req_wstrb}, {28'b0, exp_req[0].wstrb});
                        chk1("req_wen", dmem_req_wen, exp_req[0].wen);
                        if (dmem_req_ready) begin
                            void'(exp_req.pop_front());
                            hs_cnt++;
                        end
                    end
                end
                if (in_flight && !MEM_o_busy) begin
                    if (exp_out.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL missing_expectation act=output exp=none");
                    end else begin
                        chk("rdata", MEM_o_rdata, exp_out[0].rdata);
                        chk1("halt", MEM_o_system_halt, exp_out[0].halt);
                        chk("pc", MEM_o_pc, exp_out[0].pc);
                        chk("aluout", MEM_o_ALU_ALUout, exp_out[0].alu);
                        chk("rd", {27'b0, MEM_o_rd}, {27'b0, exp_out[0].rd});
                        if (!FORWARD_stallWB) begin
                            chk("handshakes", hs_cnt, exp_out[0].hs);
                            hs_cnt = 0;
                            void'(exp_out.pop_front());
                        end
                    end
                end
            end
        end
    end

    // kind: 0 non-memory, 1 load, 2 store
    task automatic issue(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input int rdy, input int rsp, input int stall,
                         input logic hin);
        int          off, idx, nb, bc, n, stall_left, exp_bc;
        logic        mis;
        logic [31:0] word, v;
        out_t        o;
        req_t        r;
        off = int'(addr % 4);
        idx = int'((addr / 4) % 16);
        mis = (kind != 0) && (((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 1)) || (f3 == 3'd2 && off != 0));
        MEM_i_mem_ren = (kind == 1); MEM_i_mem_wen = (kind == 2);
        MEM_i_funct3 = f3; MEM_i_ALU_ALUout = addr; MEM_i_rs2_data = rs2;
        MEM_i_pc = $urandom; MEM_i_inst = $urandom; MEM_i_ALU_CSR_out = $urandom;
        MEM_i_rd = 5'($urandom); MEM_i_commit = 1'($urandom); MEM_i_write_gpr = 1'($urandom);
        MEM_i_write_csr_1 = 1'($urandom); MEM_i_write_csr_2 = 1'($urandom);
        MEM_i_mem_to_reg = (kind == 1); MEM_i_csr_rd_1 = 12'($urandom); MEM_i_csr_rd_2 = 12'($urandom);
        MEM_i_system_halt = hin;
        o.pc = MEM_i_pc; o.alu = addr; o.rd = MEM_i_rd;
        o.halt = hin | mis; o.rdata = '0; o.hs = (kind != 0 && !mis) ? 1 : 0;
        exp_bc = (kind != 0 && !mis) ? 3 + rdy + rsp : 0;
        if (kind != 0 && !mis) begin
            r.addr = addr - 32'(off); r.wen = (kind == 2);
            if (kind == 1) begin
                r.wdata = '0; r.wstrb = '0;
                word = mem_model[idx];
                if (f3 == 3'd0 || f3 == 3'd4) begin
                    v = (word >> (8 * off)) & 32'd255;
                    if (f3 == 3'd0 && v > 32'd127) v = v - 32'd256;
                end else if (f3 == 3'd1 || f3 == 3'd5) begin
                    v = (word >> (8 * off)) & 32'd65535;
                    if (f3 == 3'd1 && v > 32'd32767) v = v - 32'd65536;
                end else v = word;
                o.rdata = v;
            end else begin
                nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
                r.wstrb = 4'(((1 << nb) - 1) << off);
                r.wdata = (nb == 1) ? (rs2 & 32'd255) * 32'h0101_0101 :
                          (nb == 2) ? (rs2 & 32'd65535) * 32'h0001_0001 : rs2;
                for (int j = 0; j < 4; j++)
                    if (r.wstrb[j]) mem_model[idx][8*j +: 8] = r.wdata[8*j +: 8];
            end
            exp_req.push_back(r);
        end
        exp_out.push_back(o);
        rdy_dly = rdy; rsp_dly = rsp; stall_left = stall;
        FORWARD_stallWB = (stall != 0); in_flight = 1'b1;
        bc = 0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (MEM_o_busy) bc++;
            else if (!FORWARD_stallWB) break;
            else begin
                stall_left--;
                @(posedge clk) #1;
                if (stall_left == 0) FORWARD_stallWB = 1'b0;
            end
        end
        if (n == 200) begin
            checks++; errors++;
            $display("FAIL completion_timeout act=busy exp=done_within_200");
        end
        chk("busy_cycles", bc, exp_bc);
        @(posedge clk) #1;
        in_flight = 1'b0;
    endtask

    initial begin
        int k;
        FORWARD_stallWB = 0; MEM_i_commit = 0; MEM_i_pc = '0; MEM_i_inst = '0;
        MEM_i_ALU_CSR_out = '0; MEM_i_rs2_data = '0; MEM_i_write_gpr = 0;
        MEM_i_write_csr_1 = 0; MEM_i_write_csr_2 = 0; MEM_i_mem_to_reg = 0; MEM_i_rd = '0;
        MEM_i_csr_rd_1 = '0; MEM_i_csr_rd_2 = '0; MEM_i_system_halt = 0; MEM_i_mem_wen = 0;
        foreach (mem_model[i]) mem_model[i] = $urandom;
        MEM_i_mem_ren = 1; MEM_i_funct3 = 3'd2; MEM_i_ALU_ALUout = 32'h8000_0004;
        MEM_i_pc = 32'h1234_5678;

        // A load presented during reset must not raise busy or a request.
        repeat (2) @(negedge clk);
        chk1("rst_busy", MEM_o_busy, 1'b0);
        chk1("rst_valid", dmem_req_valid, 1'b0);
        chk1("rst_wen", dmem_req_wen, 1'b0);
        chk("rst_addr", dmem_req_addr, 32'h0);
        chk("rst_wdata", dmem_req_wdata, 32'h0);
        chk("rst_wstrb", {28'b0, dmem_req_wstrb}, 32'h0);
        chk("rst_rdata", MEM_o_rdata, 32'h0);
        chk("rst_pc_pass", MEM_o_pc, 32'h1234_5678);
        @(posedge clk) #1;
        MEM_i_mem_ren = 0; rst_n = 1;
        @(posedge clk) #1;

        mem_model[0] = 32'h80FF_1234;
        issue(1, 3'd0, 32'h8000_0003, 32'h0, 0, 0, 0, 1'b0);
        issue(2, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 0, 0, 0, 1'b0);
        issue(1, 3'd2, 32'h8000_0008, 32'h0, 4, 0, 0, 1'b0);
        issue(1, 3'd5, 32'h8000_0001, 32'h0, 0, 0, 0, 1'b0);
        issue(1, 3'd0, 32'h8000_0005, 32'h0, 0, 0, 2, 1'b0);
        issue(0, 3'd0, 32'h1234_5670, 32'h0, 0, 0, 1, 1'b0);

        // Reset while waiting for a response; a late response must be ignored.
        resp_en = 0;
        MEM_i_mem_ren = 1; MEM_i_funct3 = 3'd2; MEM_i_ALU_ALUout = 32'h8000_0010;
        exp_req.push_back('{addr: 32'h8000_0010, wdata: 32'h0, wen: 1'b0, wstrb: 4'h0});
        @(posedge clk) #1;
        dmem_req_ready = 1;
        @(posedge clk) #1;
        dmem_req_ready = 0;
        @(negedge clk);
        chk1("wait_busy", MEM_o_busy, 1'b1);
        @(posedge clk) #1;
        rst_n = 0;
        #1;
        chk1("rstwait_valid", dmem_req_valid, 1'b0);
        chk1("rstwait_busy", MEM_o_busy, 1'b0);
        chk("rstwait_rdata", MEM_o_rdata, 32'h0);
        chk("rstwait_addr", dmem_req_addr, 32'h0);
        MEM_i_mem_ren = 0;
        @(posedge clk) #1;
        rst_n = 1; dmem_resp_valid = 1; dmem_resp_rdata = $urandom;
        @(negedge clk);
        chk1("late_resp_valid", dmem_req_valid, 1'b0);
        chk1("late_resp_busy", MEM_o_busy, 1'b0);
        chk("late_resp_rdata", MEM_o_rdata, 32'h0);
        @(posedge clk) #1;
        dmem_resp_valid = 0; resp_en = 1;
        @(negedge clk);
        chk("after_resp_rdata", MEM_o_rdata, 32'h0);
        @(posedge clk) #1;
        issue(1, 3'd4, 32'h8000_0012, 32'h0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            k = int'($urandom % 3);
            issue(k, (k == 1) ? ld_f3[$urandom % 5] : 3'($urandom % 3),
                  32'h8000_0000 + ($urandom % 16) * 4 + ($urandom % 4), $urandom,
                  int'($urandom % 4), int'($urandom % 4), int'($urandom % 3),
                  ($urandom % 8) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_23060136_mem_stage.md
# ysyx_23060136_mem_stage

Memory-access stage of the five-stage core: sits between the EX/MEM segment register and the MEM/WB segment register. It issues at most one data-memory transaction per instruction on a valid/ready request channel, aligns and sign/zero-extends load data, and holds the pipeline with a busy flag until the access completes. All non-memory fields pass straight through to the MEM/WB register.

## Interface
- BITS_W, 32, data/address width
- INST_W, 32, instruction width
- GPR_W, 5, GPR index width
- CSR_W, 12, CSR index width

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- FORWARD_stallWB  in  1  MEM/WB register holding this cycle
- MEM_i_commit, MEM_i_pc, MEM_i_inst, MEM_i_ALU_CSR_out, MEM_i_write_gpr, MEM_i_write_csr_1/2, MEM_i_mem_to_reg, MEM_i_rd, MEM_i_csr_rd_1/2, MEM_i_system_halt  in  per field  EX/MEM fields, forwarded unchanged on matching MEM_o_*
- MEM_i_ALU_ALUout  in  BITS_W  effective address; also forwarded as MEM_o_ALU_ALUout
- MEM_i_rs2_data  in  BITS_W  store data
- MEM_i_mem_ren / MEM_i_mem_wen  in  1  load / store; never both
- MEM_i_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  request accepted
- dmem_req_addr  out  BITS_W  word-aligned address
- dmem_req_wen  out  1  1 = write
- dmem_req_wdata  out  BITS_W  lane-replicated store data
- dmem_req_wstrb  out  BITS_W/8  byte enables
- dmem_resp_valid  in  1  response valid (always accepted)
- dmem_resp_rdata  in  BITS_W  raw read word
- MEM_o_rdata  out  BITS_W  extended load result
- MEM_o_busy  out  1  stall request to forwarding unit (stall IF..ME, bubble into MEM/WB)
- MEM_o_* pass-through  out  per field  as above; MEM_o_system_halt = MEM_i_system_halt | misalign

## Operation
- access = mem_ren | mem_wen. misalign = access & ((H/HU & addr[0]) | (W & addr[1:0]!=0)); misaligned access issues no bus request, never sets busy, forces MEM_o_system_halt=1, MEM_o_rdata=0.
- FSM: IDLE, REQ, WAIT, DONE.
  - IDLE: access & ~misalign -> REQ, latch addr/wen/wdata/wstrb/funct3/addr[1:0] into request registers.
  - REQ: dmem_req_valid=1, fields stable; on req_ready -> WAIT. valid never withdrawn before acceptance.
  - WAIT: on resp_valid -> DONE; load captures extended data into rdata register; store ignores rdata.
  - DONE: busy=0; if ~FORWARD_stallWB -> IDLE (instruction leaves stage), else stay.
- MEM_o_busy = access & ~misalign & state!=DONE (combinational; 0 during reset).
- Store: wstrb B = 1<<addr[1:0], H = 3<<addr[1:0], W = 4'hF; wdata B = {4{rs2[7:0]}}, H = {2{rs2[15:0]}}, W = rs2.
- Load: byte/halfword selected by latched addr[1:0], sign-extended for B/H, zero for BU/HU.
- MEM_o_rdata = rdata register in DONE for loads, else 0.
- No abort: accepted request always runs to its response; reset is the only cancel.

## Timing
- Reset: state IDLE, dmem_req_valid 0, req_addr/wdata/wstrb/wen 0, rdata register 0, MEM_o_busy 0; pass-throughs follow inputs.
- Zero-wait memory (ready=1 in REQ, resp_valid the next cycle): load enters cycle 0 (IDLE, busy=1), cycle 1 REQ handshake, cycle 2 WAIT response, cycle 3 DONE busy=0; MEM/WB captures at end of cycle 3 -> 3 stall cycles.
- Each extra cycle of ready=0 or resp delay adds one stall cycle.
- Non-memory instruction: busy=0, zero latency.
- resp_valid asserted outside WAIT is ignored.
- rst low mid-transaction: immediate IDLE, req_valid drops asynchronously; memory side responsible for discarding.
- Back-to-back memory instructions: DONE->IDLE then new access starts REQ one cycle later (no bubble lost beyond FSM turn).

## Test plan
- LB addr 0x8000_0003, resp word 0x80FF_1234 -> req_addr 0x8000_0000, wstrb 0, MEM_o_rdata 0xFFFF_FF80 in DONE.
- SH rs2 0x0000_ABCD addr 0x8000_0002 -> wdata 0xABCD_ABCD, wstrb 4'b1100, wen 1; busy high exactly 3 cycles with zero-wait memory.
- LW with req_ready held low 4 cycles -> req_valid and fields stable for all 4, busy 7 cycles total, single handshake.
- LHU addr 0x8000_0001 -> no req_valid, busy 0, MEM_o_system_halt 1.
- Load in DONE with FORWARD_stallWB high 2 cycles -> stays DONE, MEM_o_rdata stable, returns IDLE after stall drops.
- rst pulsed low in WAIT -> req_valid 0, state IDLE, MEM_o_rdata 0; later resp_valid ignored.
